// File: rtl/integral_box_sum_reader_pkg.sv
// -----------------------------------------------------------------------------
// integral_box_sum_reader_pkg
// Shared types and width defaults for the integral-image box-sum reader.
//   - INTEGRAL_*          : coordinate / data widths of the integral image cache
//   - READER_STATES_t     : query sequencing states of the reader
//   - CORNER_t            : selects which rectangle corner is being addressed
// -----------------------------------------------------------------------------
package integral_box_sum_reader_pkg;

    localparam int INTEGRAL_X_COUNTER_WIDTH = 9;
    localparam int INTEGRAL_Y_COUNTER_WIDTH = 9;
    localparam int INTEGRAL_DATA_WIDTH      = 32;

    typedef enum logic [2:0] {
        S_Idle = 3'd0,
        S_RdA  = 3'd1,
        S_RdB  = 3'd2,
        S_RdC  = 3'd3,
        S_RdD  = 3'd4,
        S_Last = 3'd5,
        S_Out  = 3'd6
    } READER_STATES_t;

    // A = top-left outside corner, B = top-right, C = bottom-left, D = bottom-right
    typedef enum logic [1:0] {
        CORNER_A = 2'd0,
        CORNER_B = 2'd1,
        CORNER_C = 2'd2,
        CORNER_D = 2'd3
    } CORNER_t;

endpackage

// File: rtl/integral_box_sum_reader_corner_addr.sv
// -----------------------------------------------------------------------------
// integral_box_sum_reader_corner_addr
// Combinational map from an inclusive rectangle and a corner selector to the
// integral-image address of that corner, plus a skip flag for corners that fall
// on row -1 or column -1 (their integral value is zero by definition).
//   i_x0, i_x1 : inclusive left / right columns
//   i_y0, i_y1 : inclusive top / bottom rows
//   i_corner   : corner selector (A, B, C, D)
//   o_x, o_y   : cache address of the selected corner
//   o_skip     : corner lies outside the image; do not read it
// -----------------------------------------------------------------------------
module integral_box_sum_reader_corner_addr
    import integral_box_sum_reader_pkg::*;
#(
    parameter int X_WIDTH = INTEGRAL_X_COUNTER_WIDTH,
    parameter int Y_WIDTH = INTEGRAL_Y_COUNTER_WIDTH
) (
    input  logic [X_WIDTH-1:0] i_x0,
    input  logic [Y_WIDTH-1:0] i_y0,
    input  logic [X_WIDTH-1:0] i_x1,
    input  logic [Y_WIDTH-1:0] i_y1,
    input  CORNER_t            i_corner,
    output logic [X_WIDTH-1:0] o_x,
    output logic [Y_WIDTH-1:0] o_y,
    output logic               o_skip
);

    logic [X_WIDTH-1:0] w_left;
    logic [Y_WIDTH-1:0] w_top;
    logic               w_left_out;
    logic               w_top_out;

    // Column / row just outside the rectangle; wraps when the rectangle touches
    // the image border, which is exactly the case flagged by w_*_out.
    assign w_left     = i_x0 - X_WIDTH'(1);
    assign w_top      = i_y0 - Y_WIDTH'(1);
    assign w_left_out = (i_x0 == '0);
    assign w_top_out  = (i_y0 == '0);

    always_comb begin
        o_x    = i_x1;
        o_y    = i_y1;
        o_skip = 1'b0;
        case (i_corner)
            CORNER_A: begin
                o_x    = w_left;
                o_y    = w_top;
                o_skip = w_left_out || w_top_out;
            end
            CORNER_B: begin
                o_x    = i_x1;
                o_y    = w_top;
                o_skip = w_top_out;
            end
            CORNER_C: begin
                o_x    = w_left;
                o_y    = i_y1;
                o_skip = w_left_out;
            end
            default: begin
                o_x    = i_x1;
                o_y    = i_y1;
                o_skip = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/integral_box_sum_reader.sv
// -----------------------------------------------------------------------------
// integral_box_sum_reader
// Accepts rectangle queries, reads up to four integral-image corners from the
// cache and returns the box sum D - B - C + A (modulo 2^DATA_WIDTH).
//   clk, rst_n           : clock, asynchronous active-low reset
//   image_ready          : integral image complete; gates query acceptance
//   req_valid/req_ready  : query handshake
//   req_x0/x1, req_y0/y1 : inclusive rectangle bounds
//   rd_en, rd_x, rd_y    : cache read strobe and address
//   rd_data              : cache data, valid one cycle after rd_en
//   res_valid/res_ready  : result handshake
//   res_sum, res_err     : box sum, malformed-query flag
// Fixed schedule: one cycle per corner (skipped corners still take their slot),
// so a valid query always produces its result six cycles after acceptance.
// -----------------------------------------------------------------------------
module integral_box_sum_reader
    import integral_box_sum_reader_pkg::*;
#(
    parameter int X_WIDTH    = INTEGRAL_X_COUNTER_WIDTH,
    parameter int Y_WIDTH    = INTEGRAL_Y_COUNTER_WIDTH,
    parameter int DATA_WIDTH = INTEGRAL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  image_ready,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [X_WIDTH-1:0]    req_x0,
    input  logic [X_WIDTH-1:0]    req_x1,
    input  logic [Y_WIDTH-1:0]    req_y0,
    input  logic [Y_WIDTH-1:0]    req_y1,
    output logic                  rd_en,
    output logic [X_WIDTH-1:0]    rd_x,
    output logic [Y_WIDTH-1:0]    rd_y,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_sum,
    output logic                  res_err
);

    READER_STATES_t r_state;
    READER_STATES_t w_next_state;

    logic                  r_alive;
    logic [X_WIDTH-1:0]    r_x0;
    logic [X_WIDTH-1:0]    r_x1;
    logic [Y_WIDTH-1:0]    r_y0;
    logic [Y_WIDTH-1:0]    r_y1;
    logic                  r_rd_en_d;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_c;
    logic [DATA_WIDTH-1:0] r_res_sum;
    logic                  r_res_err;

    CORNER_t               w_corner;
    logic [X_WIDTH-1:0]    w_corner_x;
    logic [Y_WIDTH-1:0]    w_corner_y;
    logic                  w_skip;
    logic                  w_is_read;
    logic                  w_accept;
    logic                  w_req_err;
    logic [DATA_WIDTH-1:0] w_captured;

    // Modular box sum; the true sum fits in DATA_WIDTH so the wrap is exact.
    function automatic logic [DATA_WIDTH-1:0] box_sum(
        input logic [DATA_WIDTH-1:0] d,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0] c,
        input logic [DATA_WIDTH-1:0] a
    );
        return d - b - c + a;
    endfunction

    always_comb begin
        w_corner = CORNER_D;
        case (r_state)
            S_RdA:   w_corner = CORNER_A;
            S_RdB:   w_corner = CORNER_B;
            S_RdC:   w_corner = CORNER_C;
            default: w_corner = CORNER_D;
        endcase
    end

    integral_box_sum_reader_corner_addr #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH)
    ) u_corner_addr (
        .i_x0     (r_x0),
        .i_y0     (r_y0),
        .i_x1     (r_x1),
        .i_y1     (r_y1),
        .i_corner (w_corner),
        .o_x      (w_corner_x),
        .o_y      (w_corner_y),
        .o_skip   (w_skip)
    );

    assign w_is_read = (r_state == S_RdA) || (r_state == S_RdB) ||
                       (r_state == S_RdC) || (r_state == S_RdD);
    // r_alive keeps req_ready low in the first cycle out of reset.
    assign w_accept  = (r_state == S_Idle) && r_alive && image_ready && req_valid;
    assign w_req_err = (req_x0 > req_x1) || (req_y0 > req_y1);
    // A corner that was not read contributes zero, whatever is on rd_data.
    assign w_captured = r_rd_en_d ? rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_Idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rd_en        = 1'b0;
        rd_x         = '0;
        rd_y         = '0;
        res_valid    = 1'b0;
        case (r_state)
            S_Idle: begin
                req_ready = r_alive && image_ready;
                if (w_accept) begin
                    w_next_state = w_req_err ? S_Out : S_RdA;
                end
            end
            S_RdA:  w_next_state = S_RdB;
            S_RdB:  w_next_state = S_RdC;
            S_RdC:  w_next_state = S_RdD;
            S_RdD:  w_next_state = S_Last;
            S_Last: w_next_state = S_Out;
            S_Out: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next_state = S_Idle;
                end
            end
            default: w_next_state = S_Idle;
        endcase
        if (w_is_read && !w_skip) begin
            rd_en = 1'b1;
            rd_x  = w_corner_x;
            rd_y  = w_corner_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive   <= 1'b0;
            r_x0      <= '0;
            r_x1      <= '0;
            r_y0      <= '0;
            r_y1      <= '0;
            r_rd_en_d <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_res_sum <= '0;
            r_res_err <= 1'b0;
        end else begin
            r_alive   <= 1'b1;
            r_rd_en_d <= rd_en;
            if (w_accept) begin
                r_x0      <= req_x0;
                r_x1      <= req_x1;
                r_y0      <= req_y0;
                r_y1      <= req_y1;
                r_res_err <= w_req_err;
                if (w_req_err) begin
                    r_res_sum <= '0;
                end
            end
            // Each corner's data arrives in the state after its read slot.
            case (r_state)
                S_RdB:  r_a       <= w_captured;
                S_RdC:  r_b       <= w_captured;
                S_RdD:  r_c       <= w_captured;
                S_Last: r_res_sum <= box_sum(w_captured, r_b, r_c, r_a);
                default: ;
            endcase
        end
    end

    assign res_sum = r_res_sum;
    assign res_err = r_res_err;

endmodule

// File: doc/integral_box_sum_reader.md
Name: integral_box_sum_reader

Overview:
- Consumer side of the integral image cache: accepts rectangle queries and returns the pixel sum inside each rectangle.
- For each query it reads up to four integral-image corners and computes D - B - C + A.
- Sits between the integral image cache read port and the downstream feature/window evaluation logic.
- Accepts queries only after integral image generation has completed.

Parameters:
- X_WIDTH, 9: column coordinate width; default equals pkg_integralImageGeneration::INTEGRAL_X_COUNTER_WIDTH.
- Y_WIDTH, 9: row coordinate width; default equals pkg_integralImageGeneration::INTEGRAL_Y_COUNTER_WIDTH.
- DATA_WIDTH, 32: integral word width; default equals pkg_integralImageGeneration::INTEGRAL_DATA_WIDTH.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- image_ready  in  1  integral image complete and stable (generator reached S_Done).
- req_valid  in  1  query valid.
- req_ready  out  1  query accepted when req_valid && req_ready.
- req_x0, req_x1  in  X_WIDTH  inclusive left and right columns.
- req_y0, req_y1  in  Y_WIDTH  inclusive top and bottom rows.
- rd_en  out  1  cache read strobe.
- rd_x  out  X_WIDTH  cache read column.
- rd_y  out  Y_WIDTH  cache read row.
- rd_data  in  DATA_WIDTH  cache data; valid exactly 1 cycle after rd_en.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  DATA_WIDTH  box sum.
- res_err  out  1  malformed query (x0>x1 or y0>y1).

Behaviour:
- Reset values: req_ready=0, rd_en=0, rd_x=0, rd_y=0, res_valid=0, res_sum=0, res_err=0, FSM=S_Idle, corner registers=0.
- Asynchronous reset mid-query aborts the query; no result is emitted for it.
- FSM states: S_Idle, S_RdA, S_RdB, S_RdC, S_RdD, S_Last, S_Out.
- S_Idle:
  - req_ready = image_ready.
  - On handshake, latch the coordinates and evaluate err = (x0>x1)||(y0>y1).
  - If err, go to S_Out with res_sum=0 and res_err=1.
  - Otherwise go to S_RdA.
- Corner addresses:
  - A = (x0-1, y0-1)
  - B = (x1, y0-1)
  - C = (x0-1, y1)
  - D = (x1, y1)
- Each S_Rd* state lasts exactly 1 cycle. Path: S_RdA -> S_RdB -> S_RdC -> S_RdD -> S_Last.
- Read suppression:
  - If a corner lies on row -1 or column -1 (x0==0 for A and C; y0==0 for A and B), rd_en=0 in that state and the corner value is forced to 0.
  - The skipped corner still consumes its cycle, so latency is fixed.
  - D is always read.
- Data capture:
  - rd_data is captured in the cycle after its read state: A in S_RdB, B in S_RdC, C in S_RdD, D in S_Last.
  - In S_Last, res_sum is registered as D - B - C + A, all modulo 2^DATA_WIDTH. Wrap is intentional and exact, since the true sum fits in DATA_WIDTH.
  - Then go to S_Out.
- S_Out:
  - res_valid=1; res_sum and res_err are held stable until res_ready.
  - On res_valid && res_ready, go to S_Idle.
  - req_ready=0 throughout S_Out; there is no query overlap.
- Latency: handshake at cycle T gives res_valid at T+6 for a valid query and T+1 for an error query.
- Throughput: one query per 7 cycles with res_ready held high.
- image_ready deasserting mid-query does not abort the query; it only blocks new acceptance.
- req_* inputs are don't-care outside a handshake cycle.

Decomposition:
- Add to pkg_integralImageGeneration, or a sibling pkg_integralBoxSum that imports it:
  - READER_STATES_t enum (logic [2:0]) with the seven states above.
  - The three width constants reused as parameter defaults.
- Natural sub-module: integral_corner_addr, a combinational unit that maps (x0,y0,x1,y1,corner index) to rd_x, rd_y and a skip flag.
- All arithmetic stays in the top module.

Test Plan:
- 8x8 all-ones image (integral I(x,y)=(x+1)(y+1)), image_ready=1, query (2,3)-(4,5):
  - 4 reads at A(1,2), B(4,2), C(1,5), D(4,5) with values 6, 15, 12, 30.
  - res_sum = 30-15-12+6 = 9 at T+6, res_err=0.
- Same image, query (0,0)-(7,7):
  - rd_en high only in S_RdD with address (7,7).
  - res_sum = 64.
- Query (5,0)-(3,2):
  - res_err=1, res_sum=0, res_valid at T+1.
  - rd_en never asserted.
- image_ready=0 with req_valid=1 for 10 cycles: req_ready stays 0. Then raise image_ready: handshake occurs the same cycle.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid:
  - res_sum is stable and req_ready=0.
  - Release: res_valid drops the next cycle and req_ready returns.
- Assert rst_n=0 during S_RdC:
  - All outputs return to their reset values immediately.
  - After release, a new query (1,1)-(1,1) on the all-ones image returns 1.
